// File: rtl/pc_fetch_gen.sv
// pc_fetch_gen: fetch-stage program-counter generator.
// Holds the fetch PC and drives a req/ack instruction-fetch handshake. The
// address is held stable until it is acknowledged. Redirects (exception,
// ERET, branch/jump) that arrive while a request is outstanding are parked
// in a pending register and applied when the ack arrives. A misaligned PC
// parks the block in an error state that only an exception can leave.

module pc_fetch_gen #(
    parameter int unsigned      WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = 32'hbfc00000,
    parameter logic [WIDTH-1:0] EXC_VEC  = 32'hbfc00380,
    parameter int unsigned      INC      = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             exc_valid,
    input  logic             eret_valid,
    input  logic [WIDTH-1:0] epc,
    input  logic             br_valid,
    input  logic [WIDTH-1:0] br_target,
    output logic             if_req,
    output logic [WIDTH-1:0] if_addr,
    input  logic             if_ack,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc_plus,
    output logic             adel,
    output logic             pend_valid
);

    // Fetch control states.
    localparam logic [1:0] ST_IDLE = 2'd0;  // no request outstanding
    localparam logic [1:0] ST_REQ  = 2'd1;  // request presented, waiting for ack
    localparam logic [1:0] ST_ERR  = 2'd2;  // misaligned PC, waiting for exception

    // Redirect priority levels. The numeric order is the priority order, so
    // a plain magnitude compare decides whether a new redirect may replace
    // the one already parked in the pending register.
    localparam logic [1:0] PRI_NONE = 2'd0;
    localparam logic [1:0] PRI_BR   = 2'd1;
    localparam logic [1:0] PRI_ERET = 2'd2;
    localparam logic [1:0] PRI_EXC  = 2'd3;

    localparam logic [WIDTH-1:0] INC_W = WIDTH'(INC);

    logic [1:0]       state, state_d;
    logic [WIDTH-1:0] pc_d;
    logic             pend_valid_d;
    logic [WIDTH-1:0] pend_pc, pend_pc_d;
    logic [1:0]       pend_pri, pend_pri_d;

    logic [1:0]       in_pri;     // priority of the redirect arriving this cycle
    logic [WIDTH-1:0] in_tgt;     // target of the redirect arriving this cycle
    logic [WIDTH-1:0] tgt;        // overall next-PC winner, pending and sequential included
    logic             pc_load;    // pc is being rewritten this cycle

    // Sequential successor; wraps modulo 2^WIDTH with no carry out.
    assign pc_plus = pc + INC_W;

    // Pick the highest-priority redirect presented on the inputs this cycle.
    always_comb begin
        // NOTE: every variable written in a combinational block gets a default
        // first, so no path through the if/else chain can infer a latch.
        in_pri = PRI_NONE;
        in_tgt = '0;
        if (exc_valid) begin
            in_pri = PRI_EXC;
            in_tgt = EXC_VEC;
        end else if (eret_valid) begin
            in_pri = PRI_ERET;
            in_tgt = epc;
        end else if (br_valid) begin
            in_pri = PRI_BR;
            in_tgt = br_target;
        end
    end

    // Resolve the full next-PC: live redirect, then pending, then sequential.
    always_comb begin
        if (in_pri != PRI_NONE) begin
            tgt = in_tgt;
        end else if (pend_valid) begin
            tgt = pend_pc;
        end else begin
            tgt = pc_plus;
        end
    end

    // Next-state, PC update and pending-register update for the fetch FSM.
    always_comb begin
        state_d      = state;
        pc_d         = pc;
        pc_load      = 1'b0;
        pend_valid_d = pend_valid;
        pend_pc_d    = pend_pc;
        pend_pri_d   = pend_pri;

        case (state)
            ST_IDLE: begin
                // No request outstanding, so a redirect lands in pc at once.
                // The ack input is meaningless here and is ignored.
                if (in_pri != PRI_NONE || pend_valid) begin
                    pc_d         = tgt;
                    pc_load      = 1'b1;
                    pend_valid_d = 1'b0;
                end
                state_d = stall ? ST_IDLE : ST_REQ;
            end

            ST_REQ: begin
                if (if_ack) begin
                    // Request accepted: move on, consuming any redirect.
                    pc_d         = tgt;
                    pc_load      = 1'b1;
                    pend_valid_d = 1'b0;
                    state_d      = stall ? ST_IDLE : ST_REQ;
                end else if (in_pri != PRI_NONE &&
                             (!pend_valid || in_pri >= pend_pri)) begin
                    // Address must stay stable; park the redirect unless a
                    // higher-priority one is already waiting.
                    pend_valid_d = 1'b1;
                    pend_pc_d    = in_tgt;
                    pend_pri_d   = in_pri;
                end
            end

            ST_ERR: begin
                // Only an exception recovers from a misaligned fetch PC.
                pend_valid_d = 1'b0;
                if (exc_valid) begin
                    pc_d    = EXC_VEC;
                    pc_load = 1'b1;
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d      = ST_IDLE;
                pend_valid_d = 1'b0;
            end
        endcase

        // Any freshly loaded PC that is not word aligned raises AdEL and
        // blocks further requests.
        if (pc_load && pc_d[1:0] != 2'b00) begin
            state_d      = ST_ERR;
            pend_valid_d = 1'b0;
        end
    end

    // State, PC and pending registers with asynchronous active-high reset.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: registers take non-blocking assignments so every flop samples
        // the pre-edge values, independent of statement order.
        if (rst) begin
            // NOTE: the pending target is reset as well even though
            // pend_valid alone gates it; it keeps simulation free of X.
            state      <= ST_IDLE;
            pc         <= RESET_PC;
            pend_valid <= 1'b0;
            pend_pc    <= '0;
            pend_pri   <= PRI_NONE;
        end else begin
            state      <= state_d;
            pc         <= pc_d;
            pend_valid <= pend_valid_d;
            pend_pc    <= pend_pc_d;
            pend_pri   <= pend_pri_d;
        end
    end

    assign if_req  = (state == ST_REQ);
    assign adel    = (state == ST_ERR);
    assign if_addr = pc;

endmodule

// File: tb/tb_pc_fetch_gen.sv
// tb_pc_fetch_gen: directed table-driven bench for pc_fetch_gen.
// Inputs are applied 1 time unit after a rising edge; outputs are compared
// 1 time unit after the following rising edge.

module tb_pc_fetch_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall, exc_valid, eret_valid, br_valid, if_ack;
    logic [31:0] epc, br_target;
    logic        if_req, adel, pend_valid;
    logic [31:0] if_addr, pc, pc_plus;

    int checks   = 0;
    int failures = 0;

    pc_fetch_gen #(
        .WIDTH   (32),
        .RESET_PC(32'hbfc00000),
        .EXC_VEC (32'hbfc00380),
        .INC     (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .stall     (stall),
        .exc_valid (exc_valid),
        .eret_valid(eret_valid),
        .epc       (epc),
        .br_valid  (br_valid),
        .br_target (br_target),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_ack    (if_ack),
        .pc        (pc),
        .pc_plus   (pc_plus),
        .adel      (adel),
        .pend_valid(pend_valid)
    );

    // 10-unit clock.
    always #5 clk = ~clk;

    typedef struct {
        logic        stall;
        logic        exc;
        logic        eret;
        logic [31:0] epc;
        logic        br;
        logic [31:0] bt;
        logic        ack;
        logic        e_req;
        logic [31:0] e_pc;
        logic        e_adel;
        logic        e_pend;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic st, logic ex, logic er, logic [31:0] ep,
                                logic b, logic [31:0] t, logic ak,
                                logic rq, logic [31:0] p, logic ad, logic pd);
        vec_t v;
        v.stall = st; v.exc = ex; v.eret = er; v.epc = ep; v.br = b; v.bt = t;
        v.ack = ak; v.e_req = rq; v.e_pc = p; v.e_adel = ad; v.e_pend = pd;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic rq, input logic [31:0] p,
                             input logic ad, input logic pd);
        logic [31:0] p_next;
        p_next = p + 32'd4;
        check({tag, " if_req"},     {31'd0, if_req},     {31'd0, rq});
        check({tag, " pc"},         pc,                  p);
        check({tag, " if_addr"},    if_addr,             p);
        check({tag, " pc_plus"},    pc_plus,             p_next);
        check({tag, " adel"},       {31'd0, adel},       {31'd0, ad});
        check({tag, " pend_valid"}, {31'd0, pend_valid}, {31'd0, pd});
    endtask

    task automatic drive(input vec_t v);
        stall      = v.stall;
        exc_valid  = v.exc;
        eret_valid = v.eret;
        epc        = v.epc;
        br_valid   = v.br;
        br_target  = v.bt;
        if_ack     = v.ack;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Sequential fetch from reset, one fetch per cycle.
        vecs.push_back(mk(0,0,0,0,0,0,1, 1,32'hbfc00000,0,0)); // v0 first req, ack ignored in IDLE
        vecs.push_back(mk(0,0,0,0,0,0,1, 1,32'hbfc00004,0,0));
        vecs.push_back(mk(0,0,0,0,0,0,1, 1,32'hbfc00008,0,0));
        vecs.push_back(mk(0,0,0,0,0,0,1, 1,32'hbfc0000c,0,0));
        vecs.push_back(mk(0,0,0,0,0,0,1, 1,32'hbfc00010,0,0)); // v4
        // Ack held low 3 cycles, branch pulse in the first -> pending.
        vecs.push_back(mk(0,0,0,0,1,32'hbfc00100,0, 1,32'hbfc00010,0,1));
        vecs.push_back(mk(0,0,0,0,0,0,0,            1,32'hbfc00010,0,1));
        vecs.push_back(mk(1,0,0,0,0,0,0,            1,32'hbfc00010,0,1)); // stall ignored in REQ
        vecs.push_back(mk(0,0,0,0,0,0,1,            1,32'hbfc00100,0,0)); // v8 pending taken
        vecs.push_back(mk(0,0,0,0,0,0,1,            1,32'hbfc00104,0,0));
        // Pending priority: br parked, exc overwrites, later br cannot.
        vecs.push_back(mk(0,0,0,0,1,32'hbfc00200,0, 1,32'hbfc00104,0,1)); // v10
        vecs.push_back(mk(0,1,0,0,0,0,0,            1,32'hbfc00104,0,1));
        vecs.push_back(mk(0,0,0,0,1,32'hbfc00300,0, 1,32'hbfc00104,0,1));
        vecs.push_back(mk(0,0,0,0,0,0,1,            1,32'hbfc00380,0,0)); // v13
        // Simultaneous exc/eret/br with ack -> exception vector wins.
        vecs.push_back(mk(0,1,1,32'h80000020,1,32'hbfc00100,1, 1,32'hbfc00380,0,0)); // v14
        vecs.push_back(mk(0,0,1,32'h80000020,0,0,1,            1,32'h80000020,0,0));
        vecs.push_back(mk(0,0,1,32'h80000040,1,32'hbfc00100,1, 1,32'h80000040,0,0)); // v16 eret > br
        // Stall on an ack cycle, held 4 cycles with ack high (ignored).
        vecs.push_back(mk(1,0,0,0,0,0,1, 0,32'h80000044,0,0)); // v17
        vecs.push_back(mk(1,0,0,0,0,0,1, 0,32'h80000044,0,0));
        vecs.push_back(mk(1,0,0,0,0,0,1, 0,32'h80000044,0,0));
        vecs.push_back(mk(1,0,0,0,0,0,1, 0,32'h80000044,0,0));
        vecs.push_back(mk(1,0,0,0,0,0,1, 0,32'h80000044,0,0)); // v21
        vecs.push_back(mk(0,0,0,0,0,0,0, 1,32'h80000044,0,0)); // v22 resume
        vecs.push_back(mk(0,0,0,0,0,0,1, 1,32'h80000048,0,0));
        vecs.push_back(mk(1,0,0,0,0,0,0, 1,32'h80000048,0,0)); // v24 stall without ack: no effect
        vecs.push_back(mk(0,0,0,0,0,0,1, 1,32'h8000004c,0,0));
        // Redirect while idle lands directly in pc.
        vecs.push_back(mk(1,0,0,0,0,0,1,            0,32'h80000050,0,0)); // v26
        vecs.push_back(mk(1,0,0,0,1,32'hbfc00400,0, 0,32'hbfc00400,0,0));
        vecs.push_back(mk(0,0,0,0,0,0,0,            1,32'hbfc00400,0,0)); // v28
        // Misaligned branch -> ERR; only exc leaves it.
        vecs.push_back(mk(0,0,0,0,1,32'hbfc00102,1, 0,32'hbfc00102,1,0)); // v29
        vecs.push_back(mk(0,0,0,0,1,32'hbfc00500,1, 0,32'hbfc00102,1,0));
        vecs.push_back(mk(0,0,1,32'h80000000,0,0,1, 0,32'hbfc00102,1,0));
        vecs.push_back(mk(0,1,0,0,0,0,0,            0,32'hbfc00380,0,0)); // v32
        vecs.push_back(mk(0,0,0,0,0,0,0,            1,32'hbfc00380,0,0));
        // Wrap-around at the top of the address space.
        vecs.push_back(mk(0,0,0,0,1,32'hfffffffc,1, 1,32'hfffffffc,0,0)); // v34
        vecs.push_back(mk(0,0,0,0,0,0,1,            1,32'h00000000,0,0));
        vecs.push_back(mk(0,0,0,0,0,0,1,            1,32'h00000004,0,0)); // v36

        // Reset state, checked while reset is still asserted.
        rst = 1'b1;
        drive(mk(0,0,0,0,0,0,0, 0,0,0,0));
        #1;
        check_all("reset", 1'b0, 32'hbfc00000, 1'b0, 1'b0);
        #12 rst = 1'b0;

        foreach (vecs[i]) begin
            drive(vecs[i]);
            step();
            check_all($sformatf("v%0d", i), vecs[i].e_req, vecs[i].e_pc,
                      vecs[i].e_adel, vecs[i].e_pend);
        end

        // Park a redirect, then assert reset mid-request between edges.
        drive(mk(0,0,0,0,1,32'hbfc00700,0, 0,0,0,0));
        step();
        check_all("pre_rst", 1'b1, 32'h00000004, 1'b0, 1'b1);
        drive(mk(0,0,0,0,0,0,1, 0,0,0,0));
        rst = 1'b1;
        #1;
        check_all("async_rst", 1'b0, 32'hbfc00000, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        step();
        check_all("post_rst", 1'b1, 32'hbfc00000, 1'b0, 1'b0);
        step();
        check_all("post_rst2", 1'b1, 32'hbfc00004, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
